// File: rtl/mult_issue_ctrl_if.sv
// Bus bundle for mult_issue_ctrl: issue-slot requests, multiplier drive/return, CDB side and error flag.
// master = surrounding pipeline/multiplier/CDB, slave = the issue controller.
`ifndef XLEN
`define XLEN 32
`endif

interface mult_issue_ctrl_if #(
  parameter int unsigned TAG_W = 5
);
  logic                        squash;
  logic [1:0]                  req_valid;
  logic [1:0][`XLEN-1:0]       req_opa;
  logic [1:0][`XLEN-1:0]       req_opb;
  logic [1:0][1:0]             req_func;
  logic [1:0][TAG_W-1:0]       req_tag;
  logic [1:0]                  req_grant;
  logic                        fu_issue;
  logic [`XLEN-1:0]            fu_opa;
  logic [`XLEN-1:0]            fu_opb;
  logic [1:0]                  fu_func;
  logic                        fu_done;
  logic [`XLEN-1:0]            fu_result;
  logic                        cdb_req;
  logic [TAG_W-1:0]            cdb_tag;
  logic [`XLEN-1:0]            cdb_value;
  logic                        cdb_grant;
  logic                        proto_err;

  modport master (
    output squash, req_valid, req_opa, req_opb, req_func, req_tag,
    output fu_done, fu_result, cdb_grant,
    input  req_grant, fu_issue, fu_opa, fu_opb, fu_func,
    input  cdb_req, cdb_tag, cdb_value, proto_err
  );

  modport slave (
    input  squash, req_valid, req_opa, req_opb, req_func, req_tag,
    input  fu_done, fu_result, cdb_grant,
    output req_grant, fu_issue, fu_opa, fu_opb, fu_func,
    output cdb_req, cdb_tag, cdb_value, proto_err
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Round-robin issue controller and credit-managed result FIFO for the shared fixed-latency multiplier.
// Optional MULT_ISSUE_PERF_EN adds saturating issue and credit-stall counters.
`ifndef XLEN
`define XLEN 32
`endif

module mult_issue_ctrl #(
  parameter int unsigned LAT       = 4,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned TAG_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  mult_issue_ctrl_if.slave bus
`ifdef MULT_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_credit_stall
`endif
);

  localparam int unsigned XW     = `XLEN;
  localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned USED_W = $clog2(LAT + BUF_DEPTH + 2);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    value;
  } cdb_entry_t;

  logic             rr_q;
  logic             iss_valid_q;
  logic [XW-1:0]    iss_opa_q;
  logic [XW-1:0]    iss_opb_q;
  logic [1:0]       iss_func_q;
  logic [TAG_W-1:0] iss_tag_q;

  logic [LAT-1:0]   occ_q;
  logic [LAT-1:0]   live_q;
  logic [TAG_W-1:0] tag_q [LAT];

  cdb_entry_t       fifo_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             proto_err_q;

  logic [USED_W-1:0] pipe_cnt;
  logic [USED_W-1:0] used;
  logic              grant_ok;
  logic [1:0]        grant;
  logic              grant_idx;
  logic              any_grant;
  logic              fifo_empty;
  logic              fifo_full;
  logic              ret_occ;
  logic              ret_live;
  logic              push;
  logic              pop;
  logic              err_set;
  cdb_entry_t        head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits consumed: ops in the multiplier, the issue register and buffered results.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      pipe_cnt = pipe_cnt + USED_W'(occ_q[i]);
    end
    used = pipe_cnt + USED_W'(iss_valid_q) + USED_W'(count_q);
  end

  assign grant_ok = (used < USED_W'(BUF_DEPTH)) & ~bus.squash & ~reset;

  always_comb begin
    grant = 2'b00;
    if (grant_ok) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_idx  = grant[1];
  assign any_grant  = |grant;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(BUF_DEPTH));
  assign ret_occ    = occ_q[LAT-1];
  assign ret_live   = live_q[LAT-1];
  assign push       = bus.fu_done & ret_occ & ret_live & ~bus.squash & ~fifo_full;
  assign pop        = ~fifo_empty & bus.cdb_grant;
  assign err_set    = (bus.fu_done & ~ret_occ) | (~bus.fu_done & ret_occ)
                    | (bus.fu_done & ret_occ & ret_live & ~bus.squash & fifo_full);
  assign head       = fifo_q[rd_ptr_q];

  assign bus.req_grant = grant;
  assign bus.fu_issue  = iss_valid_q;
  assign bus.fu_opa    = iss_opa_q;
  assign bus.fu_opb    = iss_opb_q;
  assign bus.fu_func   = iss_func_q;
  assign bus.cdb_req   = ~fifo_empty;
  assign bus.cdb_tag   = fifo_empty ? '0 : head.tag;
  assign bus.cdb_value = fifo_empty ? '0 : head.value;
  assign bus.proto_err = proto_err_q;

  // Issue register and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q        <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_opa_q   <= '0;
      iss_opb_q   <= '0;
      iss_func_q  <= '0;
      iss_tag_q   <= '0;
    end else begin
      iss_valid_q <= any_grant;
      if (any_grant) begin
        rr_q       <= ~grant_idx;
        iss_opa_q  <= bus.req_opa[grant_idx];
        iss_opb_q  <= bus.req_opb[grant_idx];
        iss_func_q <= bus.req_func[grant_idx];
        iss_tag_q  <= bus.req_tag[grant_idx];
      end
    end
  end

  // Tag pipe mirrors the multiplier; squash kills liveness but keeps occupancy for credit return.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q  <= '0;
      live_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      occ_q[0]  <= iss_valid_q;
      live_q[0] <= iss_valid_q & ~bus.squash;
      tag_q[0]  <= iss_tag_q;
      for (int i = 1; i < LAT; i++) begin
        occ_q[i]  <= occ_q[i-1];
        live_q[i] <= live_q[i-1] & ~bus.squash;
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.squash) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{tag: tag_q[LAT-1], value: bus.fu_result};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_q | err_set;
  end

`ifdef MULT_ISSUE_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issued       <= '0;
      perf_credit_stall <= '0;
    end else begin
      if (iss_valid_q && (perf_issued != 32'hFFFF_FFFF)) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if ((|bus.req_valid) && !bus.squash && !any_grant &&
          (perf_credit_stall != 32'hFFFF_FFFF)) begin
        perf_credit_stall <= perf_credit_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl: directed issue/credit/squash/error/reset scenarios.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mult_issue_ctrl;
  localparam int unsigned LAT       = 4;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned XW        = `XLEN;
  localparam int unsigned DW        = 2 * XW;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    value;
  } exp_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_q [$];

  logic [LAT-1:0] mv;
  logic [XW-1:0]  mr [LAT];
  logic           mdl_done;
  logic [XW-1:0]  mdl_res;
  logic           force_done;

`ifdef MULT_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_credit_stall;
`endif

  mult_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  mult_issue_ctrl #(.LAT(LAT), .BUF_DEPTH(BUF_DEPTH), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef MULT_ISSUE_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_credit_stall (perf_credit_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.fu_done   = mdl_done | force_done;
  assign bus.fu_result = mdl_res;

  function automatic logic [XW-1:0] mul_ref(input logic [1:0] f, input logic [XW-1:0] a,
                                            input logic [XW-1:0] b);
    logic [DW-1:0] p;
    case (f)
      2'd1:    p = DW'($signed(a)) * DW'($signed(b));
      2'd2:    p = DW'($signed(a)) * DW'(b);
      default: p = DW'(a) * DW'(b);
    endcase
    return (f == 2'd0) ? p[XW-1:0] : p[DW-1:XW];
  endfunction

  // Fixed-latency multiplier stand-in.
  always @(posedge clock) begin
    logic          iss;
    logic          rst_s;
    logic [XW-1:0] a;
    logic [XW-1:0] b;
    logic [1:0]    f;
    iss   = bus.fu_issue;
    a     = bus.fu_opa;
    b     = bus.fu_opb;
    f     = bus.fu_func;
    rst_s = reset;
    #1;
    if (rst_s) begin
      mv       = '0;
      mdl_done = 1'b0;
      mdl_res  = '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0]    = iss;
      mr[0]    = mul_ref(f, a, b);
      mdl_done = mv[LAT-1];
      mdl_res  = mr[LAT-1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // CDB monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b0 && bus.cdb_req === 1'b1 && bus.cdb_grant === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cdb_unexpected: got tag=%0d value=0x%0h, required no result (t=%0t)",
                 bus.cdb_tag, bus.cdb_value, $time);
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag", 64'(bus.cdb_tag), 64'(e.tag));
        chk("cdb_value", 64'(bus.cdb_value), 64'(e.value));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int s, input logic v, input logic [1:0] f,
                          input logic [XW-1:0] a, input logic [XW-1:0] b,
                          input logic [TAG_W-1:0] t);
    bus.req_valid[s] = v;
    bus.req_func[s]  = f;
    bus.req_opa[s]   = a;
    bus.req_opb[s]   = b;
    bus.req_tag[s]   = t;
  endtask

  task automatic expect_res(input logic [TAG_W-1:0] t, input logic [XW-1:0] v);
    exp_t e;
    e.tag   = t;
    e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.squash     = 1'b0;
    bus.req_valid  = 2'b11;
    bus.req_opa    = '0;
    bus.req_opb    = '0;
    bus.req_func   = '0;
    bus.req_tag    = '0;
    bus.cdb_grant  = 1'b0;
    force_done     = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    chk("rst_req_grant", 64'(bus.req_grant), 64'd0);
    chk("rst_fu_issue", 64'(bus.fu_issue), 64'd0);
    chk("rst_cdb_req", 64'(bus.cdb_req), 64'd0);
    chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
    bus.req_valid = 2'b00;
    reset         = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.cdb_grant = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100us");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    mdl_done   = 1'b0;
    mdl_res    = '0;
    force_done = 1'b0;
    mv         = '0;

    // Single MUL op: grant in cycle 0, issue in cycle 1, result on CDB in cycle 6.
    do_reset();
    bus.cdb_grant = 1'b1;
    set_slot(0, 1'b1, 2'd0, 32'd7, 32'd6, 5'd3);
    expect_res(5'd3, 32'd42);
    @(negedge clock); chk("t1_grant", 64'(bus.req_grant), 64'b01);
    tick(); set_slot(0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clock);
    chk("t1_fu_issue", 64'(bus.fu_issue), 64'd1);
    chk("t1_fu_opa", 64'(bus.fu_opa), 64'd7);
    chk("t1_fu_opb", 64'(bus.fu_opb), 64'd6);
    chk("t1_fu_func", 64'(bus.fu_func), 64'd0);
    tick(); @(negedge clock); chk("t1_issue_once", 64'(bus.fu_issue), 64'd0);
    repeat (3) tick();
    @(negedge clock); chk("t1_cdb_req_c5", 64'(bus.cdb_req), 64'd0);
    tick();
    @(negedge clock);
    chk("t1_cdb_req_c6", 64'(bus.cdb_req), 64'd1);
    chk("t1_cdb_tag_c6", 64'(bus.cdb_tag), 64'd3);
    chk("t1_cdb_value_c6", 64'(bus.cdb_value), 64'd42);
    tick(); @(negedge clock); chk("t1_cdb_req_popped", 64'(bus.cdb_req), 64'd0);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Contention: both slots every cycle, grants alternate starting at slot0.
    do_reset();
    bus.cdb_grant = 1'b1;
    set_slot(0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'd2, 5'd1);
    set_slot(1, 1'b1, 2'd0, 32'd3, 32'd5, 5'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t2_grant", 64'(bus.req_grant), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k % 2 == 0) expect_res(5'd1, 32'h0000_0001);
      else            expect_res(5'd2, 32'd15);
      tick();
    end
    bus.req_valid = 2'b00;
    drain("t2_drain");

    // Credit stall: four grants fill the buffer, one pop admits exactly one more.
    do_reset();
    set_slot(0, 1'b1, 2'd0, 32'd2, 32'd3, 5'd4);
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      chk("t3_grant", 64'(bus.req_grant), (k < 4) ? 64'b01 : 64'b00);
      if (k < 4) expect_res(5'd4, 32'd6);
      tick();
    end
    bus.cdb_grant = 1'b1;
    @(negedge clock); chk("t3_grant_pop_cycle", 64'(bus.req_grant), 64'b00);
    tick(); bus.cdb_grant = 1'b0;
    @(negedge clock); chk("t3_grant_after_pop", 64'(bus.req_grant), 64'b01);
    expect_res(5'd4, 32'd6);
    tick();
    @(negedge clock); chk("t3_grant_refull", 64'(bus.req_grant), 64'b00);
    tick(); bus.req_valid = 2'b00;
    drain("t3_drain");

    // Squash blocks the grant in its own cycle and leaves the RR pointer alone.
    do_reset();
    bus.cdb_grant = 1'b1;
    bus.squash = 1'b1;
    set_slot(0, 1'b1, 2'd0, 32'd1, 32'd1, 5'd9);
    @(negedge clock); chk("t4_squash_no_grant", 64'(bus.req_grant), 64'b00);
    tick(); bus.squash = 1'b0;
    set_slot(0, 1'b1, 2'd0, 32'd2, 32'd2, 5'd9);
    set_slot(1, 1'b1, 2'd0, 32'd2, 32'd3, 5'd8);
    @(negedge clock);
    chk("t4_no_issue_after_squash", 64'(bus.fu_issue), 64'd0);
    chk("t4_rr_kept", 64'(bus.req_grant), 64'b01);
    expect_res(5'd9, 32'd4);
    tick(); bus.req_valid = 2'b00;
    drain("t4a_drain");

    // Squash with three ops in flight and one buffered.
    do_reset();
    set_slot(0, 1'b1, 2'd0, 32'd1, 32'd5, 5'd10);
    tick(); bus.req_valid = 2'b00;
    tick(); set_slot(1, 1'b1, 2'd0, 32'd1, 32'd6, 5'd11);
    tick(); set_slot(1, 1'b1, 2'd0, 32'd1, 32'd7, 5'd12);
    tick(); set_slot(1, 1'b1, 2'd0, 32'd1, 32'd8, 5'd13);
    @(negedge clock); chk("t4_grant_c4", 64'(bus.req_grant), 64'b10);
    tick(); bus.req_valid = 2'b00;
    tick();
    bus.squash = 1'b1;
    set_slot(0, 1'b1, 2'd0, 32'd1, 32'd1, 5'd14);
    @(negedge clock);
    chk("t4_cdb_req_s", 64'(bus.cdb_req), 64'd1);
    chk("t4_grant_s", 64'(bus.req_grant), 64'b00);
    tick();
    bus.squash    = 1'b0;
    bus.req_valid = 2'b00;
    bus.cdb_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t4_cdb_req_flushed", 64'(bus.cdb_req), 64'd0);
      if (k == 0) chk("t4_fu_issue_s1", 64'(bus.fu_issue), 64'd0);
      tick();
    end
    bus.cdb_grant = 1'b0;
    set_slot(0, 1'b1, 2'd0, 32'd9, 32'd9, 5'd20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t4_credit_back", 64'(bus.req_grant), (k < 4) ? 64'b01 : 64'b00);
      if (k < 4) expect_res(5'd20, 32'd81);
      tick();
    end
    bus.req_valid = 2'b00;
    drain("t4_drain");
    chk("t4_proto_err", 64'(bus.proto_err), 64'd0);

    // Protocol error: a result with nothing in flight is sticky until reset.
    do_reset();
    tick();
    force_done = 1'b1;
    @(negedge clock); chk("t5_err_before", 64'(bus.proto_err), 64'd0);
    tick(); force_done = 1'b0;
    @(negedge clock); chk("t5_err_set", 64'(bus.proto_err), 64'd1);
    repeat (5) tick();
    chk("t5_err_sticky", 64'(bus.proto_err), 64'd1);

    // Async reset in mid-stream clears outputs without a clock edge.
    do_reset();
    set_slot(0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'd2, 5'd1);
    set_slot(1, 1'b1, 2'd0, 32'd3, 32'd5, 5'd2);
    repeat (3) tick();
    #1; chk("t6_busy", 64'(bus.fu_issue), 64'd1);
    #1; reset = 1'b1;
    #1;
    chk("t6_fu_issue", 64'(bus.fu_issue), 64'd0);
    chk("t6_req_grant", 64'(bus.req_grant), 64'd0);
    chk("t6_fu_opa", 64'(bus.fu_opa), 64'd0);
    chk("t6_cdb_req", 64'(bus.cdb_req), 64'd0);
    exp_q.delete();
    tick(); reset = 1'b0;
    @(negedge clock); chk("t6_first_grant", 64'(bus.req_grant), 64'b01);
    expect_res(5'd1, 32'h0000_0001);
    tick(); bus.req_valid = 2'b00;
    drain("t6_drain");
    chk("t6_proto_err", 64'(bus.proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Issue controller and result buffer for the shared pipelined multiply unit. It arbitrates round-robin between the two superscalar issue slots and drives a fixed-latency multiplier. It tracks ROB tags alongside each in-flight op and queues completed results until the CDB grants them. A credit scheme guarantees every issued op has a buffer slot, so the multiplier itself never needs to stall.

Parameters:
LAT, 4, fixed latency in cycles from fu_issue to fu_done; legal range 1..8
BUF_DEPTH, 4, result FIFO entries; must be >= 1, power of 2
TAG_W, 5, ROB tag width

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
squash  in  1  synchronous flush of all ops (branch mispredict)
req_valid  in  2  per-slot issue request
req_opa  in  2x`XLEN  operand A per slot
req_opb  in  2x`XLEN  operand B per slot
req_func  in  2x2  multiply op per slot: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
req_tag  in  2xTAG_W  ROB tag per slot
req_grant  out  2  combinational, one-hot or zero
fu_issue  out  1  registered issue strobe to multiplier
fu_opa  out  `XLEN  registered operand A
fu_opb  out  `XLEN  registered operand B
fu_func  out  2  registered op select
fu_done  in  1  multiplier result valid
fu_result  in  `XLEN  multiplier result
cdb_req  out  1  FIFO non-empty
cdb_tag  out  TAG_W  head-entry tag
cdb_value  out  `XLEN  head-entry value
cdb_grant  in  1  CDB accepts head this cycle
proto_err  out  1  sticky error flag

Behaviour:
- Reset state: all outputs 0, FIFO empty, tag pipe empty, RR pointer = 0, proto_err = 0.
- Credits:
  - used = occupied tag-pipe slots + issue register (if valid) + FIFO occupancy, all taken from registered state.
  - Grant is allowed only when used < BUF_DEPTH and squash = 0.
  - A pop in cycle t frees its credit from cycle t+1.
- Arbitration:
  - At most one grant per cycle.
  - If both slots request, grant the slot at the RR pointer.
  - If one slot requests, grant it regardless of the pointer.
  - After any grant, the pointer moves to the other slot.
- Issue:
  - The granted slot's opa/opb/func/tag are captured at the clock edge.
  - fu_issue = 1 for exactly one cycle, the cycle after the grant.
- Tag pipe:
  - LAT-deep shift register; each entry holds {occ, live, tag}.
  - The entry enters when fu_issue is high.
  - Slot LAT-1 is aligned with fu_done.
- Return, on fu_done:
  - Slot occupied and live: push {tag, fu_result} into the FIFO.
  - Slot occupied, not live: drop silently.
  - Slot unoccupied: drop and set proto_err.
  - fu_done low while slot LAT-1 is occupied also sets proto_err (missed result).
- FIFO and CDB:
  - cdb_req = ~empty; cdb_tag/cdb_value show the head.
  - Pop when cdb_req & cdb_grant.
  - Push and pop in the same cycle keep the count unchanged.
  - The credit scheme makes overflow impossible; a push while full sets proto_err and drops the push.
- Squash (cycle s):
  - Clears every live bit, the issue register (fu_issue at s+1 = 0), and the FIFO (cdb_req = 0 from s+1).
  - No grant in cycle s.
  - Occ bits stay set, so squashed ops still hold their credit until they return.
  - RR pointer unchanged.
  - A CDB pop in cycle s is still honoured.
- Reset mid-operation: all state clears asynchronously; proto_err clears only on reset.

Optional Feature:
MULT_ISSUE_PERF_EN
- Defined:
  - Adds outputs perf_issued[31:0] (count of fu_issue cycles) and perf_credit_stall[31:0] (cycles with any req_valid, no squash, and no grant).
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op, LAT=4: slot0 sends MUL 7x6, tag 3, at cycle 0, cdb_grant held 1 -> req_grant=01 in cycle 0; fu_issue in cycle 1; cdb_req with tag 3 / value 42 in cycle 6.
- Contention: both slots request every cycle -> grants alternate 01,10,01,10; MULHU 0xFFFFFFFF x 2 returns 0x00000001.
- Credit stall: BUF_DEPTH=4, cdb_grant=0, slot0 requesting continuously -> exactly 4 grants, then req_grant=00 indefinitely. Raising cdb_grant for 1 cycle gives 1 pop, then 1 new grant the next cycle.
- Squash with 3 ops in flight and 1 buffered -> cdb_req=0 next cycle; the 3 fu_done returns are dropped, proto_err stays 0, and all credits are recovered LAT cycles later.
- Protocol error: fu_done pulsed with the tag pipe empty -> proto_err=1 and stays 1 until reset.
- Async reset asserted mid-stream without a clock edge -> all outputs 0 immediately; after release, the first grant goes to slot0.
